// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcode classes,
// trap causes and the datapath steering bundle.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Opcode classes as seen in ir[6:2] (ir[1:0] must be 2'b11)
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       conc_en;
    logic       jal;
    logic       jalr;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
  } steer_t;

  localparam steer_t STEER_NONE = '0;

endpackage

// File: rtl/multicycle_control_unit_ctrl_decode.sv
// Combinational opcode decode: maps ir[6:0] to the steering bundle, class
// flags used by the FSM, and an illegal-instruction flag.
module ctrl_decode
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] opcode,
  output steer_t     steer,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       illegal
);

  always_comb begin
    steer     = STEER_NONE;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    if (opcode[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode[6:2])
        OPC_OP: begin
          steer.alu_op = 2'b10;
        end
        OPC_OPIMM: begin
          steer.alu_op    = 2'b10;
          steer.alu_src_a = 1'b1;
        end
        OPC_LOAD: begin
          is_load          = 1'b1;
          steer.mem_to_reg = 2'b01;
          steer.alu_src_a  = 1'b1;
        end
        OPC_STORE: begin
          is_store        = 1'b1;
          steer.alu_src_a = 1'b1;
        end
        OPC_BRANCH: begin
          is_branch    = 1'b1;
          steer.branch = 1'b1;
          steer.alu_op = 2'b01;
        end
        OPC_AUIPC: begin
          steer.alu_src_a = 1'b1;
          steer.alu_src_b = 1'b1;
          steer.conc_en   = 1'b1;
        end
        OPC_JAL: begin
          steer.mem_to_reg = 2'b10;
          steer.alu_src_a  = 1'b1;
          steer.jal        = 1'b1;
        end
        OPC_JALR: begin
          steer.mem_to_reg = 2'b10;
          steer.alu_src_a  = 1'b1;
          steer.jalr       = 1'b1;
        end
        OPC_LUI: begin
          steer.mem_to_reg = 2'b11;
          steer.alu_op     = 2'b11;
          steer.alu_src_a  = 1'b1;
          steer.conc_en    = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with instruction
// register, bus-wait timeout, sticky trap and retired-instruction counter.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  instr,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             pc_write,
  output logic             ir_write,
  output logic             Branch,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             ConcEn,
  output logic             Jal,
  output logic             Jalr,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUOp,
  output logic [XLEN-1:0]  ir,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   ir_q;
  logic [CNT_W-1:0]  instret_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic              run_q;
  logic              req, expire, ld_ir, retire, steer_en;

  steer_t steer;
  logic   is_load, is_store, is_branch, illegal;

  ctrl_decode u_decode (
    .opcode    (ir_q[6:0]),
    .steer     (steer),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .illegal   (illegal)
  );

  // run_q keeps mem_req low from reset assertion until the first clock edge after release
  assign req    = run_q && (state_q == ST_FETCH || state_q == ST_MEM);
  assign expire = req && !mem_ack && (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      run_q     <= 1'b0;
      ir_q      <= '0;
      instret_q <= '0;
      wait_q    <= '0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (ld_ir)  ir_q      <= instr;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ld_ir   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (req && mem_ack) begin
          ld_ir   = 1'b1;
          state_d = ST_DECODE;
        end else if (expire) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_load || is_store) begin
          state_d = ST_MEM;
        end else if (is_branch) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (is_load) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (expire) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_TRAP;
    endcase
  end

  // Wait counter restarts on each entry to a requesting state; an ack on the
  // expiry cycle wins because expire requires !mem_ack.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q && (state_d == ST_FETCH || state_d == ST_MEM)) begin
      wait_d = '0;
    end else if (req && !mem_ack) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_comb begin
    steer_en = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
               (state_q == ST_MEM)    || (state_q == ST_WB);
    mem_req  = req;
    MemRead  = (req && state_q == ST_FETCH) || (state_q == ST_MEM && is_load);
    MemWrite = (state_q == ST_MEM) && is_store;
    ir_write = req && (state_q == ST_FETCH) && mem_ack;
    RegWrite = (state_q == ST_WB);
    pc_write = (state_q == ST_WB) || (state_q == ST_EXEC && is_branch);
    Branch   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 1'b0;
    ConcEn   = 1'b0;
    Jal      = 1'b0;
    Jalr     = 1'b0;
    MemtoReg = 2'b00;
    ALUOp    = 2'b00;
    if (steer_en) begin
      Branch   = steer.branch;
      ALUSrcA  = steer.alu_src_a;
      ALUSrcB  = steer.alu_src_b;
      ConcEn   = steer.conc_en;
      Jal      = steer.jal;
      Jalr     = steer.jalr;
      MemtoReg = steer.mem_to_reg;
      ALUOp    = steer.alu_op;
    end
  end

  assign ir         = ir_q;
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule
